// File: rtl/boxcar_decimator_if.sv
// Sample-in / result-out bundle for the boxcar decimator.
// The slave side is the decimator and the master side is the producer/consumer pair.
interface boxcar_decimator_if #(
    parameter int LOG2_R = 2,
    parameter int DATA_W = 16
);
    localparam int ACC_W = DATA_W + LOG2_R;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_ready;
    logic                     clear_overrun;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_sum;
    logic signed [DATA_W-1:0] out_data;
    logic                     overrun;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  clear_overrun,
        output out_valid,
        output out_sum,
        output out_data,
        output overrun
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output clear_overrun,
        input  out_valid,
        input  out_sum,
        input  out_data,
        input  overrun
    );
endinterface

// File: rtl/boxcar_decimator.sv
// Decimate-by-2^LOG2_R boxcar: sums each block of valid samples and holds the sum and
// its floor average in a drop-oldest output register with a sticky overrun flag.
module boxcar_decimator #(
    parameter int LOG2_R = 2,
    parameter int DATA_W = 16,
    localparam int ACC_W = DATA_W + LOG2_R
) (
    input  logic                clk,
    input  logic                reset,
    boxcar_decimator_if.slave   bus
);
    localparam logic [LOG2_R-1:0] CNT_LAST = '1;

    logic [LOG2_R-1:0]       cnt, cnt_next;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic signed [ACC_W-1:0] sum_reg, sum_reg_next;
    logic                    valid_reg, valid_reg_next;
    logic                    overrun_reg, overrun_reg_next;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] block_sum;
    logic                    complete;
    logic                    take;

    // ACC_W is exact for R full-scale samples, so this add can never wrap.
    assign sample_ext = {{LOG2_R{bus.in_data[DATA_W-1]}}, bus.in_data};
    assign block_sum  = acc + sample_ext;
    assign complete   = bus.in_valid && (cnt == CNT_LAST);
    assign take       = valid_reg && bus.out_ready;

    always_comb begin
        cnt_next         = cnt;
        acc_next         = acc;
        sum_reg_next     = sum_reg;
        valid_reg_next   = valid_reg;
        overrun_reg_next = overrun_reg;

        if (bus.in_valid) begin
            if (complete) begin
                cnt_next     = '0;
                acc_next     = '0;
                sum_reg_next = block_sum;
            end else begin
                cnt_next = cnt + 1'b1;
                acc_next = block_sum;
            end
        end

        if (complete) begin
            valid_reg_next = 1'b1;
        end else if (take) begin
            valid_reg_next = 1'b0;
        end

        // Losing an untaken result outranks a same-cycle clear request.
        if (complete && valid_reg && !bus.out_ready) begin
            overrun_reg_next = 1'b1;
        end else if (bus.clear_overrun) begin
            overrun_reg_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            sum_reg     <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            acc         <= acc_next;
            sum_reg     <= sum_reg_next;
            valid_reg   <= valid_reg_next;
            overrun_reg <= overrun_reg_next;
        end
    end

    // The average is a bit-select of the registered sum, i.e. a floor shift.
    assign bus.out_sum   = sum_reg;
    assign bus.out_data  = sum_reg[ACC_W-1:LOG2_R];
    assign bus.out_valid = valid_reg;
    assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed bench for boxcar_decimator with LOG2_R=2 (R=4), DATA_W=16.
// Inputs change 1 ns after a rising edge and outputs are checked there as well.
module tb_boxcar_decimator;
    logic clk;
    logic reset;
    int   tests_run;
    int   fail_count;

    boxcar_decimator_if #(.LOG2_R(2), .DATA_W(16)) bus ();

    boxcar_decimator #(.LOG2_R(2), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int data);
        bus.in_valid = valid;
        bus.in_data  = 16'(data);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
    endtask

    task automatic checkResult(input string tag, input int sum, input int avg);
        checkOutput({tag, " valid"}, int'(bus.out_valid), 1);
        checkOutput({tag, " sum"}, int'(bus.out_sum), sum);
        checkOutput({tag, " data"}, int'(bus.out_data), avg);
    endtask

    initial begin
        tests_run         = 0;
        fail_count        = 0;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.out_ready     = 1'b0;
        bus.clear_overrun = 1'b0;
        step();
        step();
        checkOutput("reset valid", int'(bus.out_valid), 0);
        checkOutput("reset sum", int'(bus.out_sum), 0);
        checkOutput("reset data", int'(bus.out_data), 0);
        checkOutput("reset overrun", int'(bus.overrun), 0);

        // Basic sum, result visible for exactly one cycle with out_ready high
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b1, 3);
        checkOutput("basic early valid", int'(bus.out_valid), 0);
        applyStimulus(1'b1, 4);
        checkResult("basic", 10, 2);
        idle(1);
        checkOutput("basic one cycle", int'(bus.out_valid), 0);

        // Negative floor rounding, then a positive block
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -2);
        checkResult("neg", -5, -2);
        applyStimulus(1'b1, 5);
        checkOutput("neg taken", int'(bus.out_valid), 0);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        checkResult("pos", 5, 1);

        // Full scale in both directions
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32767);
        checkResult("fullpos", 131068, 32767);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, -32768);
        checkResult("fullneg", -131072, -32768);
        idle(1);
        checkOutput("fullneg taken", int'(bus.out_valid), 0);

        // Gaps inside a block, result held under backpressure
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 1);
        idle(2);
        applyStimulus(1'b1, 1);
        idle(1);
        applyStimulus(1'b1, 1);
        idle(3);
        checkOutput("gap early valid", int'(bus.out_valid), 0);
        applyStimulus(1'b1, 1);
        checkResult("gap", 4, 1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            checkOutput("gap hold valid", int'(bus.out_valid), 1);
            checkOutput("gap hold sum", int'(bus.out_sum), 4);
        end
        bus.out_ready = 1'b1;
        idle(1);
        bus.out_ready = 1'b0;
        checkOutput("gap taken", int'(bus.out_valid), 0);
        checkOutput("gap overrun", int'(bus.overrun), 0);
        idle(1);
        checkOutput("gap ready no effect", int'(bus.out_valid), 0);

        // Overrun: drop oldest, set beats clear, then clear alone
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1);
        checkResult("ovr first", 4, 1);
        checkOutput("ovr first flag", int'(bus.overrun), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2);
        checkResult("ovr second", 8, 2);
        checkOutput("ovr set", int'(bus.overrun), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3);
        bus.clear_overrun = 1'b1;
        applyStimulus(1'b1, 3);
        checkResult("ovr third", 12, 3);
        checkOutput("ovr set wins", int'(bus.overrun), 1);
        idle(1);
        bus.clear_overrun = 1'b0;
        checkOutput("ovr cleared", int'(bus.overrun), 0);
        checkOutput("ovr still held", int'(bus.out_sum), 12);

        // Take and completion on the same edge: reload, no overrun
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 6);
        checkResult("simul", 24, 6);
        checkOutput("simul overrun", int'(bus.overrun), 0);
        idle(1);
        bus.out_ready = 1'b0;
        checkOutput("simul taken", int'(bus.out_valid), 0);

        // Reset discards a held result and a partial block, overriding in_valid
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2);
        checkResult("pre reset", 8, 2);
        applyStimulus(1'b1, 7);
        applyStimulus(1'b1, 7);
        reset = 1'b1;
        applyStimulus(1'b1, 9);
        checkOutput("in reset valid", int'(bus.out_valid), 0);
        checkOutput("in reset sum", int'(bus.out_sum), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1);
            checkOutput("post reset valid", int'(bus.out_valid), 0);
        end
        applyStimulus(1'b1, 1);
        checkResult("post reset", 4, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
